// File: rtl/navic_l1_pkg.sv
// navic_l1_pkg: shared constants and state encoding for the NavIC L1 PRN streamer
package navic_l1_pkg;
  localparam int CODE_LEN = 1800;
  localparam int REG_W = 10;
  localparam int CAP_W = 24;
  localparam int IDX_W = 11;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/navic_l1_prn_streamer_if.sv
// navic_l1_prn_streamer_if: control, seed, symbol handshake and chip output bundle of the PRN streamer
interface navic_l1_prn_streamer_if;
  import navic_l1_pkg::*;
  logic start, stop, chip_en, sym_valid, sym_bit, sym_ready;
  logic [0:REG_W-1] R0_in, R1_in;
  logic chip_out, chip_valid, epoch_start, busy, underrun;
  logic [IDX_W-1:0] chip_idx;
  logic [0:CAP_W-1] first, last;
  modport master(
    output start, stop, R0_in, R1_in, chip_en, sym_valid, sym_bit,
    input sym_ready, chip_out, chip_valid, epoch_start, busy, underrun, chip_idx, first, last
  );
  modport slave(
    input start, stop, R0_in, R1_in, chip_en, sym_valid, sym_bit,
    output sym_ready, chip_out, chip_valid, epoch_start, busy, underrun, chip_idx, first, last
  );
endinterface

// File: rtl/navic_l1_prn_step.sv
// navic_l1_prn_step: one combinational advance of the R0/R1 code registers, bit 0 is the output stage
module navic_l1_prn_step
  import navic_l1_pkg::*;
(
  input  logic [0:REG_W-1] R0,
  input  logic [0:REG_W-1] R1,
  output logic [0:REG_W-1] R0_next,
  output logic [0:REG_W-1] R1_next,
  output logic chip
);
  logic r_pl, s2, fb1;
  assign r_pl = R0[5] ^ R0[2] ^ R0[1] ^ R0[0];
  assign s2 = ((R0[5] ^ R0[2]) & (R0[1] ^ R0[0])) ^ ((R0[5] & R0[2]) ^ (R0[1] & R0[0]));
  assign fb1 = s2 ^ R0[6] ^ R0[3] ^ R0[2] ^ R0[0] ^ R1[5] ^ R1[2] ^ R1[1] ^ R1[0];
  assign R0_next = {R0[1:REG_W-1], r_pl};
  assign R1_next = {R1[1:REG_W-1], fb1};
  assign chip = R1[0];
endmodule

// File: rtl/navic_l1_prn_streamer.sv
// navic_l1_prn_streamer: NavIC L1 PRN chip streamer with per-epoch symbol modulation.
// NAVIC_PRN_CAPTURE_EN adds capture of the first and last 24 code chips of each epoch.
module navic_l1_prn_streamer
  import navic_l1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  navic_l1_prn_streamer_if.slave io
);
  state_t state, state_nx;
  logic [0:REG_W-1] seed0, seed1, r0, r1, r0_nx, r1_nx;
  logic [IDX_W-1:0] idx;
  logic chip, go, adv, xfer, epoch_head, epoch_end, sym_now;
  logic buf_full, buf_bit, cur_sym, under_q, out_q, valid_q, epoch_q;

  navic_l1_prn_step u_step (.R0(r0), .R1(r1), .R0_next(r0_nx), .R1_next(r1_nx), .chip(chip));

  assign go = state == IDLE && io.start && !io.stop;
  assign adv = state == RUN && io.chip_en && !io.stop;
  assign epoch_head = idx == '0;
  assign epoch_end = idx == IDX_W'(CODE_LEN - 1);
  assign xfer = io.sym_valid && io.sym_ready;
  // the symbol for a new epoch modulates its own chip 0
  assign sym_now = epoch_head ? buf_full && buf_bit : cur_sym;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb state_nx = io.stop ? IDLE : go ? RUN : state;

  always_comb begin
    io.busy = state == RUN;
    io.sym_ready = state == RUN && !buf_full;
    io.chip_out = out_q;
    io.chip_valid = valid_q;
    io.epoch_start = epoch_q;
    io.underrun = under_q;
    io.chip_idx = idx;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seed0 <= '0;
      seed1 <= '0;
      r0 <= '0;
      r1 <= '0;
      idx <= '0;
      cur_sym <= 1'b0;
      under_q <= 1'b0;
      out_q <= 1'b0;
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
      buf_full <= 1'b0;
      buf_bit <= 1'b0;
    end else begin
      valid_q <= adv;
      epoch_q <= adv && epoch_head;
      if (adv) out_q <= chip ^ sym_now;
      if (go) begin
        seed0 <= io.R0_in;
        seed1 <= io.R1_in;
        r0 <= io.R0_in;
        r1 <= io.R1_in;
        idx <= '0;
        under_q <= 1'b0;
      end else if (adv) begin
        r0 <= epoch_end ? seed0 : r0_nx;
        r1 <= epoch_end ? seed1 : r1_nx;
        idx <= epoch_end ? '0 : idx + 1'b1;
        if (epoch_head) cur_sym <= buf_full && buf_bit;
        if (epoch_head && !buf_full) under_q <= 1'b1;
      end
      buf_full <= !io.stop && (xfer || (buf_full && !(adv && epoch_head)));
      if (xfer) buf_bit <= io.sym_bit;
    end

`ifdef NAVIC_PRN_CAPTURE_EN
  logic [0:CAP_W-2] cap_sh;
  logic [0:CAP_W-1] win, first_q, last_q;
  // win holds the 24 most recent code chips, oldest in bit 0
  assign win = {cap_sh, chip};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap_sh <= '0;
      first_q <= '0;
      last_q <= '0;
    end else if (adv) begin
      cap_sh <= win[1:CAP_W-1];
      if (idx == IDX_W'(CAP_W - 1)) first_q <= win;
      if (epoch_end) last_q <= win;
    end
  assign io.first = first_q;
  assign io.last = last_q;
`else
  assign io.first = '0;
  assign io.last = '0;
`endif
endmodule

// File: tb/tb_navic_l1_prn_streamer.sv
// tb_navic_l1_prn_streamer: directed self-checking bench for the NavIC L1 PRN streamer
module tb_navic_l1_prn_streamer;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_bad = 0;
  logic mdl [0:1799];
  logic [0:9] sa0 = 10'b1100110101, sa1 = 10'b1011000111;
  logic [0:9] sb0 = 10'b0111010010, sb1 = 10'b1001101100;

  navic_l1_prn_streamer_if bus();
  navic_l1_prn_streamer dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_model(input logic [0:9] s0, input logic [0:9] s1);
    logic [0:9] r0, r1;
    logic rpl, s2, fb;
    r0 = s0;
    r1 = s1;
    for (int k = 0; k < 1800; k++) begin
      mdl[k] = r1[0];
      rpl = r0[5] ^ r0[2] ^ r0[1] ^ r0[0];
      s2 = ((r0[5] ^ r0[2]) & (r0[1] ^ r0[0])) ^ ((r0[5] & r0[2]) ^ (r0[1] & r0[0]));
      fb = s2 ^ r0[6] ^ r0[3] ^ r0[2] ^ r0[0] ^ r1[5] ^ r1[2] ^ r1[1] ^ r1[0];
      r0 = {r0[1:9], rpl};
      r1 = {r1[1:9], fb};
    end
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
  endtask

  task automatic do_start(input logic [0:9] s0, input logic [0:9] s1);
    bus.R0_in = s0;
    bus.R1_in = s1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.chip_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.chip_valid); end
    n_cmp++; if (bus.chip_out !== 1'b0) begin n_bad++; $display("FAIL reset_chip_out got=%b exp=0", bus.chip_out); end
    n_cmp++; if (bus.epoch_start !== 1'b0) begin n_bad++; $display("FAIL reset_epoch got=%b exp=0", bus.epoch_start); end
    n_cmp++; if (bus.underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun got=%b exp=0", bus.underrun); end
    n_cmp++; if (bus.sym_ready !== 1'b0) begin n_bad++; $display("FAIL reset_sym_ready got=%b exp=0", bus.sym_ready); end
    n_cmp++; if (bus.chip_idx !== 11'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", bus.chip_idx); end
    n_cmp++; if (bus.first !== 24'd0 || bus.last !== 24'd0) begin n_bad++; $display("FAIL reset_capture got=%h/%h exp=0/0", bus.first, bus.last); end
  endtask

  task automatic test_zero_seed_underrun();
    do_start(10'd0, 10'd0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy got=%b exp=1", bus.busy); end
    bus.chip_en = 1'b1;
    for (int k = 0; k < 1801; k++) begin
      cycle();
      n_cmp++; if (bus.chip_valid !== 1'b1 || bus.chip_out !== 1'b0) begin n_bad++; $display("FAIL zero_chip k=%0d got=%b/%b exp=1/0", k, bus.chip_valid, bus.chip_out); end
      n_cmp++; if (bus.epoch_start !== (k % 1800 == 0)) begin n_bad++; $display("FAIL zero_epoch k=%0d got=%b exp=%b", k, bus.epoch_start, k % 1800 == 0); end
    end
    bus.chip_en = 1'b0;
    n_cmp++; if (bus.underrun !== 1'b1) begin n_bad++; $display("FAIL zero_underrun got=%b exp=1", bus.underrun); end
  endtask

  task automatic test_symbol();
    do_stop();
    n_cmp++; if (bus.busy !== 1'b0 || bus.chip_valid !== 1'b0) begin n_bad++; $display("FAIL sym_stop got=%b/%b exp=0/0", bus.busy, bus.chip_valid); end
    do_start(10'd0, 10'd0);
    n_cmp++; if (bus.sym_ready !== 1'b1) begin n_bad++; $display("FAIL sym_ready_empty got=%b exp=1", bus.sym_ready); end
    bus.sym_valid = 1'b1;
    bus.sym_bit = 1'b1;
    cycle();
    bus.sym_valid = 1'b0;
    n_cmp++; if (bus.sym_ready !== 1'b0) begin n_bad++; $display("FAIL sym_ready_full got=%b exp=0", bus.sym_ready); end
    bus.chip_en = 1'b1;
    for (int k = 0; k < 1800; k++) begin
      cycle();
      n_cmp++; if (bus.chip_valid !== 1'b1 || bus.chip_out !== 1'b1) begin n_bad++; $display("FAIL sym_chip k=%0d got=%b/%b exp=1/1", k, bus.chip_valid, bus.chip_out); end
    end
    bus.chip_en = 1'b0;
    n_cmp++; if (bus.underrun !== 1'b0) begin n_bad++; $display("FAIL sym_underrun got=%b exp=0", bus.underrun); end
    n_cmp++; if (bus.sym_ready !== 1'b1) begin n_bad++; $display("FAIL sym_ready_drained got=%b exp=1", bus.sym_ready); end
  endtask

  task automatic test_prn_two_epochs();
    logic [0:23] ef, el;
    gen_model(sa0, sa1);
`ifdef NAVIC_PRN_CAPTURE_EN
    for (int j = 0; j < 24; j++) begin
      ef[j] = mdl[j];
      el[j] = mdl[1776 + j];
    end
`else
    ef = '0;
    el = '0;
`endif
    do_stop();
    do_start(sa0, sa1);
    bus.chip_en = 1'b1;
    for (int k = 0; k < 3600; k++) begin
      cycle();
      n_cmp++; if (bus.chip_valid !== 1'b1 || bus.chip_out !== mdl[k % 1800]) begin n_bad++; $display("FAIL prn_chip k=%0d got=%b/%b exp=1/%b", k, bus.chip_valid, bus.chip_out, mdl[k % 1800]); end
      n_cmp++; if (bus.epoch_start !== (k % 1800 == 0)) begin n_bad++; $display("FAIL prn_epoch k=%0d got=%b exp=%b", k, bus.epoch_start, k % 1800 == 0); end
      if (k < 10) begin
        n_cmp++; if (bus.chip_out !== sa1[k]) begin n_bad++; $display("FAIL prn_seed_chip k=%0d got=%b exp=%b", k, bus.chip_out, sa1[k]); end
      end
      if (k == 1798) begin
        n_cmp++; if (bus.chip_idx !== 11'd1799) begin n_bad++; $display("FAIL prn_idx_last got=%0d exp=1799", bus.chip_idx); end
      end
      if (k == 1799) begin
        n_cmp++; if (bus.chip_idx !== 11'd0) begin n_bad++; $display("FAIL prn_idx_wrap got=%0d exp=0", bus.chip_idx); end
        n_cmp++; if (bus.first !== ef) begin n_bad++; $display("FAIL cap_first got=%h exp=%h", bus.first, ef); end
        n_cmp++; if (bus.last !== el) begin n_bad++; $display("FAIL cap_last got=%h exp=%h", bus.last, el); end
      end
    end
    bus.chip_en = 1'b0;
  endtask

  task automatic test_strobe_gap();
    int n = 0;
    gen_model(sa0, sa1);
    do_stop();
    do_start(sa0, sa1);
    n_cmp++; if (bus.chip_valid !== 1'b0) begin n_bad++; $display("FAIL gap_idle_valid got=%b exp=0", bus.chip_valid); end
    for (int c = 0; c < 540; c++) begin
      bus.chip_en = (c % 3 == 0);
      cycle();
      n_cmp++; if (bus.chip_valid !== (c % 3 == 0)) begin n_bad++; $display("FAIL gap_valid c=%0d got=%b exp=%b", c, bus.chip_valid, c % 3 == 0); end
      if (c % 3 == 0) begin
        n_cmp++; if (bus.chip_out !== mdl[n]) begin n_bad++; $display("FAIL gap_chip n=%0d got=%b exp=%b", n, bus.chip_out, mdl[n]); end
        n++;
      end
    end
    bus.chip_en = 1'b0;
  endtask

  task automatic test_stop_restart();
    do_stop();
    do_start(sa0, sa1);
    bus.chip_en = 1'b1;
    repeat (900) cycle();
    n_cmp++; if (bus.chip_idx !== 11'd900 || bus.underrun !== 1'b1) begin n_bad++; $display("FAIL restart_mid got=%0d/%b exp=900/1", bus.chip_idx, bus.underrun); end
    do_stop();
    n_cmp++; if (bus.busy !== 1'b0 || bus.chip_valid !== 1'b0) begin n_bad++; $display("FAIL restart_stop got=%b/%b exp=0/0", bus.busy, bus.chip_valid); end
    bus.chip_en = 1'b0;
    do_start(sb0, sb1);
    n_cmp++; if (bus.busy !== 1'b1 || bus.chip_idx !== 11'd0 || bus.underrun !== 1'b0) begin n_bad++; $display("FAIL restart_go got=%b/%0d/%b exp=1/0/0", bus.busy, bus.chip_idx, bus.underrun); end
    gen_model(sb0, sb1);
    bus.chip_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      n_cmp++; if (bus.chip_out !== mdl[k] || bus.epoch_start !== (k == 0)) begin n_bad++; $display("FAIL restart_chip k=%0d got=%b/%b exp=%b/%b", k, bus.chip_out, bus.epoch_start, mdl[k], k == 0); end
    end
    bus.chip_en = 1'b0;
  endtask

  task automatic test_idle_controls();
    do_stop();
    bus.chip_en = 1'b1;
    cycle();
    n_cmp++; if (bus.chip_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_chip_en got=%b/%b exp=0/0", bus.chip_valid, bus.busy); end
    bus.chip_en = 1'b0;
    bus.stop = 1'b1;
    do_start(sa0, sa1);
    bus.stop = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_stop_wins got=%b exp=0", bus.busy); end
    gen_model(sb0, sb1);
    do_start(sb0, sb1);
    bus.R0_in = sa0;
    bus.R1_in = sa1;
    bus.start = 1'b1;
    bus.chip_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      bus.start = 1'b0;
      n_cmp++; if (bus.chip_out !== mdl[k] || bus.chip_idx !== 11'(k + 1)) begin n_bad++; $display("FAIL run_start_ignored k=%0d got=%b/%0d exp=%b/%0d", k, bus.chip_out, bus.chip_idx, mdl[k], k + 1); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.chip_valid !== 1'b0 || bus.chip_idx !== 11'd0 || bus.underrun !== 1'b0) begin n_bad++; $display("FAIL midrst got=%b/%b/%0d/%b exp=0/0/0/0", bus.busy, bus.chip_valid, bus.chip_idx, bus.underrun); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++; if (bus.chip_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_after k=%0d got=%b/%b exp=0/0", k, bus.chip_valid, bus.busy); end
    end
    bus.chip_en = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.chip_en = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_bit = 1'b0;
    bus.R0_in = '0;
    bus.R1_in = '0;
    repeat (2) cycle();
    test_reset();
    rst = 1'b0;
    cycle();
    test_reset();
    test_zero_seed_underrun();
    test_symbol();
    test_prn_two_epochs();
    test_strobe_gap();
    test_stop_restart();
    test_idle_controls();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
